// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that holds a grant for a whole valid/ready burst, with a beat watchdog.
// One IDLE cycle per burst for arbitration; downstream ready passes combinationally to the owner only.
module rr_burst_arbiter #(
    parameter  int N         = 4,
    parameter  int DW        = 32,
    parameter  int MAX_BEATS = 16,
    localparam int IW        = (N > 1) ? $clog2(N) : 1,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid_i,
    input  logic [N*DW-1:0] req_data_i,
    input  logic [N-1:0]    req_last_i,
    output logic [N-1:0]    req_ready_o,
    output logic            out_valid_o,
    output logic [DW-1:0]   out_data_o,
    output logic            out_last_o,
    input  logic            out_ready_i,
    output logic [IW-1:0]   grant_idx_o,
    output logic            grant_valid_o,
    output logic            err_timeout_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [IW:0] NW = (IW + 1)'(N);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;

    logic [IW:0]   cand;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          own_valid;
    logic          own_last;
    logic [DW-1:0] own_data;
    logic          force_last;

    // Rotating priority search starting at ptr_q, wrapping modulo N.
    always_comb begin
        cand     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IW + 1)'(k);
            if (cand >= NW) begin
                cand = cand - NW;
            end
            if (!pick_vld && req_valid_i[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == IW'(i)) begin
                own_valid = req_valid_i[i];
                own_last  = req_last_i[i];
                own_data  = req_data_i[i*DW +: DW];
            end
        end
    end

    assign force_last = (beat_cnt_q == CW'(MAX_BEATS - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = 1'b0;
        req_ready_o = '0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                out_valid_o = own_valid;
                out_data_o  = own_data;
                out_last_o  = (own_last | force_last) & own_valid;
                for (int i = 0; i < N; i++) begin
                    req_ready_o[i] = (grant_q == IW'(i)) & out_ready_i;
                end
                if (out_valid_o && out_ready_i) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (out_last_o) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        ptr_d      = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
                        // Flag only releases the watchdog caused, not a genuine last on the final beat.
                        err_d      = force_last & ~own_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign grant_idx_o   = grant_q;
    assign grant_valid_o = (state_q == BUSY);
    assign err_timeout_o = err_q;

endmodule
